// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - Pipeline record types shared between the panda core stages.
package panda_pkg;

    typedef enum logic [1:0] {
        RD_DATA_ALU    = 2'd0,
        RD_DATA_PC_INC = 2'd1,
        RD_DATA_IMM    = 2'd2,
        RD_DATA_LOAD   = 2'd3
    } rd_data_sel_e;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_width_e;

    typedef struct packed {
        logic [31:0]  alu_result;
        logic [31:0]  pc_inc;
        rd_data_sel_e rd_data_sel;
        logic [4:0]   rd_addr;
        logic         rd_we;
        logic         lsu_store;
        lsu_width_e   lsu_width;
        logic         lsu_load_unsigned;
        logic [31:0]  imm;
        logic [31:0]  rs2_data;
        logic [4:0]   rs2_addr;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] rd_data;
    } mem_wb_t;

endpackage

// File: rtl/panda_mem_stage.sv
// rtl/panda_mem_stage.sv - MEM stage: load/store over a req/gnt/rvalid data port, MEM/WB register.
// Define PANDA_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module panda_mem_stage
    import panda_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  ex_mem_t     ex_mem_i,
    output mem_wb_t     mem_wb_o,
    output logic        stall_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

    state_e      state_q, state_d;
    logic        is_load, is_store, mem_op, misalign, issue, fwd;
    logic [1:0]  off;
    logic [3:0]  be_c, be_q;
    logic [31:0] store_src, wdata_c, wdata_q, addr_c, addr_q;
    logic [31:0] lane, load_data, alu_data;
    logic        we_q, load_q, unsigned_q;
    lsu_width_e  width_q;
    logic [1:0]  off_q;
    mem_wb_t     wb_d;

    assign is_load  = (ex_mem_i.rd_data_sel == RD_DATA_LOAD);
    assign is_store = ex_mem_i.lsu_store;
    assign mem_op   = is_load || is_store;
    assign off      = ex_mem_i.alu_result[1:0];
    assign addr_c   = {ex_mem_i.alu_result[31:2], 2'b00};

`ifdef PANDA_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign misalign = mem_op &&
        (((ex_mem_i.lsu_width == LSU_HALF) && off[0]) ||
         ((ex_mem_i.lsu_width != LSU_BYTE) && (ex_mem_i.lsu_width != LSU_HALF) && (off != 2'b00)));
    assign misaligned_o = misaligned_q;
`else
    assign misalign     = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    assign issue = mem_op && !misalign;

    // Forward the instruction that just wrote back, which the regfile read in EX could not see.
    assign fwd       = mem_wb_o.rd_we && (mem_wb_o.rd_addr == ex_mem_i.rs2_addr) && (ex_mem_i.rs2_addr != 5'd0);
    assign store_src = fwd ? mem_wb_o.rd_data : ex_mem_i.rs2_data;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_src;
        case (ex_mem_i.lsu_width)
            LSU_BYTE: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{store_src[7:0]}};
            end
            LSU_HALF: begin
                be_c    = 4'b0011 << off;
                wdata_c = {2{store_src[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = data_rdata_i >> {off_q, 3'b000};

    always_comb begin
        load_data = data_rdata_i;
        case (width_q)
            LSU_BYTE: load_data = unsigned_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            LSU_HALF: load_data = unsigned_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default:  ;
        endcase
    end

    always_comb begin
        case (ex_mem_i.rd_data_sel)
            RD_DATA_PC_INC: alu_data = ex_mem_i.pc_inc;
            RD_DATA_IMM:    alu_data = ex_mem_i.imm;
            default:        alu_data = ex_mem_i.alu_result;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        data_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    data_req_o = 1'b1;
                    stall_o    = 1'b1;
                    state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                stall_o    = 1'b1;
                if (data_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) state_d = IDLE;
                else               stall_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The request is driven live in IDLE and from the latched copy afterwards, so a writeback
    // bubble changing the forwarding source cannot disturb an outstanding request.
    assign data_addr_o  = (state_q == IDLE) ? addr_c   : addr_q;
    assign data_be_o    = (state_q == IDLE) ? be_c     : be_q;
    assign data_wdata_o = (state_q == IDLE) ? wdata_c  : wdata_q;
    assign data_we_o    = (state_q == IDLE) ? is_store : we_q;

    always_comb begin
        wb_d = '0;
        if (!stall_o) begin
            if (state_q == IDLE && !misalign) begin
                wb_d.rd_addr = ex_mem_i.rd_addr;
                wb_d.rd_we   = ex_mem_i.rd_we;
                wb_d.rd_data = alu_data;
            end else if (state_q == WAIT_RVALID) begin
                wb_d.rd_addr = ex_mem_i.rd_addr;
                wb_d.rd_we   = load_q && ex_mem_i.rd_we;
                wb_d.rd_data = load_q ? load_data : 32'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mem_wb_o   <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            load_q     <= 1'b0;
            unsigned_q <= 1'b0;
            width_q    <= LSU_BYTE;
            off_q      <= 2'b00;
        end else begin
            state_q  <= state_d;
            mem_wb_o <= wb_d;
            if (state_q == IDLE && issue) begin
                addr_q     <= addr_c;
                be_q       <= be_c;
                wdata_q    <= wdata_c;
                we_q       <= is_store;
                load_q     <= is_load && !is_store;
                unsigned_q <= ex_mem_i.lsu_load_unsigned;
                width_q    <= ex_mem_i.lsu_width;
                off_q      <= off;
            end
        end
    end

`ifdef PANDA_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) misaligned_q <= 1'b0;
        else       misaligned_q <= (state_q == IDLE) && misalign;
    end
`endif

endmodule

// File: tb/tb_panda_mem_stage.sv
// tb/tb_panda_mem_stage.sv - Randomized scoreboard bench for panda_mem_stage.
module tb_panda_mem_stage;
    import panda_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    ex_mem_t     ex_mem_i = '0;
    mem_wb_t     mem_wb_o;
    logic        stall_o, data_req_o, data_we_o, misaligned_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [31:0] data_rdata_i = 32'd0;
    logic [3:0]  data_be_o;

    panda_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .ex_mem_i(ex_mem_i), .mem_wb_o(mem_wb_o),
        .stall_o(stall_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
    } req_t;

    typedef struct {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];

    int checks = 0;
    int errors = 0;

    // Architectural view of the last writeback, used to predict store forwarding.
    logic        prev_we = 1'b0;
    logic [4:0]  prev_addr = 5'd0;
    logic [31:0] prev_data = 32'd0;
    logic        mis_next = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int width_bytes(input lsu_width_e w);
        if (w == LSU_BYTE) return 1;
        if (w == LSU_HALF) return 2;
        return 4;
    endfunction

    task automatic issue(input ex_mem_t op, input logic [31:0] rdata, input int gd, input int rvd);
        logic        is_load, is_store, mis, fwd, wr;
        int          size, raw_off, off, n;
        logic [31:0] src, v, wdata, res;
        logic [3:0]  be;
        req_t        r;
        wb_t         w;
        is_load  = (op.rd_data_sel == RD_DATA_LOAD);
        is_store = op.lsu_store;
        size     = width_bytes(op.lsu_width);
        raw_off  = int'(op.alu_result[1:0]);
        off      = (size == 4) ? 0 : raw_off;
        mis      = 1'b0;
`ifdef PANDA_MISALIGN_TRAP_EN
        mis = (is_load || is_store) && ((raw_off % size) != 0);
`endif
        wr  = 1'b0;
        res = 32'd0;
        @(posedge clk_i); #2;
        ex_mem_i = op;
        if ((is_load || is_store) && !mis) begin
            fwd = prev_we && (prev_addr == op.rs2_addr) && (op.rs2_addr != 5'd0);
            src = fwd ? prev_data : op.rs2_data;
            for (int i = 0; i < 4; i++) begin
                be[i] = (i >= off) && (i < off + size);
                wdata[8*i +: 8] = src[8*(i % size) +: 8];
            end
            r.addr = {op.alu_result[31:2], 2'b00};
            r.be = be; r.we = is_store; r.wdata = wdata; r.rdata = rdata;
            r.gnt_dly = gd; r.rv_dly = rvd;
            req_q.push_back(r);
            if (is_load && !is_store) begin
                v = rdata >> (8 * off);
                if (size == 1)      res = op.lsu_load_unsigned ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
                else if (size == 2) res = op.lsu_load_unsigned ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else                res = v;
                wr = op.rd_we;
            end
        end else if (!is_load && !is_store) begin
            wr  = op.rd_we;
            res = (op.rd_data_sel == RD_DATA_PC_INC) ? op.pc_inc :
                  (op.rd_data_sel == RD_DATA_IMM)    ? op.imm : op.alu_result;
        end
        if (wr) begin
            w.rd_addr = op.rd_addr; w.rd_data = res;
            wb_q.push_back(w);
        end
        prev_we = wr; prev_addr = op.rd_addr; prev_data = res;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (!stall_o) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL stall_timeout stall_o stuck high after %0d cycles", n);
                break;
            end
        end
        check("stall_cycles", 64'(n), 64'(((is_load || is_store) && !mis) ? gd + rvd : 0));
        mis_next = mis;
    endtask

    // Writeback / misalign monitor.
    always begin
        wb_t e;
        @(posedge clk_i); #1;
        if (!rst_i) begin
            check("misaligned", 64'(misaligned_o), 64'(mis_next));
            mis_next = 1'b0;
            if (mem_wb_o.rd_we) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_writeback rd_addr=%0d rd_data=%h expected none", mem_wb_o.rd_addr, mem_wb_o.rd_data);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_rd_addr", 64'(mem_wb_o.rd_addr), 64'(e.rd_addr));
                    check("wb_rd_data", 64'(mem_wb_o.rd_data), 64'(e.rd_data));
                end
            end
        end
    end

    // Memory responder: checks each request cycle, grants after gnt_dly, answers after rv_dly.
    int          gcnt = 0, rv_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] rv_data = 32'd0;

    always begin
        req_t cur;
        @(posedge clk_i); #3;
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i = $urandom;
        if (pend) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                data_rvalid_i = 1'b1;
                data_rdata_i = rv_data;
                pend = 1'b0;
            end
        end
        if (data_req_o) begin
            if (req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req addr=%h expected no request", data_addr_o);
            end else begin
                cur = req_q[0];
                check("req_addr", 64'(data_addr_o), 64'(cur.addr));
                check("req_be", 64'(data_be_o), 64'(cur.be));
                check("req_we", 64'(data_we_o), 64'(cur.we));
                if (cur.we) check("req_wdata", 64'(data_wdata_o), 64'(cur.wdata));
                if (gcnt == cur.gnt_dly) begin
                    data_gnt_i = 1'b1;
                    pend = 1'b1;
                    rv_cnt = cur.rv_dly;
                    rv_data = cur.rdata;
                    void'(req_q.pop_front());
                    gcnt = 0;
                end else begin
                    gcnt++;
                end
            end
        end
        if (!pend && !data_rvalid_i && $urandom_range(0, 3) == 0) data_rvalid_i = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        ex_mem_t op;
        req_t    r;
        int      kind;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_mem_wb", 64'(mem_wb_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_req", 64'(data_req_o), 64'd0);
        check("reset_misaligned", 64'(misaligned_o), 64'd0);

        op = '0; op.rd_data_sel = RD_DATA_LOAD; op.lsu_width = LSU_WORD;
        op.alu_result = 32'h100; op.rd_addr = 5'd1; op.rd_we = 1'b1;
        issue(op, 32'hDEADBEEF, 0, 1);

        op.lsu_width = LSU_BYTE; op.alu_result = 32'h103; op.rd_addr = 5'd2;
        issue(op, 32'h80123456, 0, 1);
        op.lsu_load_unsigned = 1'b1;
        issue(op, 32'h80123456, 1, 2);

        op = '0; op.lsu_store = 1'b1; op.lsu_width = LSU_HALF; op.alu_result = 32'h202;
        op.rs2_data = 32'h0000ABCD;
        issue(op, 32'd0, 3, 1);

        for (int pass = 0; pass < 2; pass++) begin
            op = '0; op.rd_data_sel = RD_DATA_ALU; op.alu_result = 32'h11;
            op.rd_addr = 5'd5; op.rd_we = 1'b1;
            issue(op, 32'd0, 0, 1);
            op = '0; op.lsu_store = 1'b1; op.lsu_width = LSU_BYTE; op.alu_result = 32'h300;
            op.rs2_data = 32'h99; op.rs2_addr = (pass == 0) ? 5'd5 : 5'd0;
            issue(op, 32'd0, 1, 1);
        end

`ifdef PANDA_MISALIGN_TRAP_EN
        op = '0; op.rd_data_sel = RD_DATA_LOAD; op.lsu_width = LSU_WORD;
        op.alu_result = 32'h101; op.rd_addr = 5'd3; op.rd_we = 1'b1;
        issue(op, 32'd0, 0, 1);
`endif

        for (int k = 0; k < 300; k++) begin
            op = '0;
            kind = $urandom_range(0, 2);
            op.alu_result = $urandom; op.pc_inc = $urandom; op.imm = $urandom; op.rs2_data = $urandom;
            op.rd_addr = 5'($urandom_range(0, 3));
            op.rs2_addr = 5'($urandom_range(0, 3));
            op.rd_we = ($urandom_range(0, 3) != 0);
            op.lsu_width = lsu_width_e'(2'($urandom_range(0, 2)));
            op.lsu_load_unsigned = ($urandom_range(0, 1) == 1);
            op.rd_data_sel = rd_data_sel_e'(2'($urandom_range(0, 2)));
            if (kind == 1) begin
                op.rd_data_sel = RD_DATA_LOAD;
                if (op.lsu_width == LSU_HALF) op.alu_result[0] = 1'b0;
                if (op.lsu_width == LSU_WORD) op.alu_result[1:0] = 2'b00;
            end else if (kind == 2) begin
                op.lsu_store = 1'b1;
            end
            issue(op, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        op = '0; op.rd_data_sel = RD_DATA_LOAD; op.lsu_width = LSU_WORD;
        op.alu_result = 32'h400; op.rd_addr = 5'd7; op.rd_we = 1'b1;
        @(posedge clk_i); #2;
        ex_mem_i = op;
        r.addr = 32'h400; r.be = 4'hF; r.we = 1'b0; r.wdata = 32'd0; r.rdata = 32'h12345678;
        r.gnt_dly = 0; r.rv_dly = 2;
        req_q.push_back(r);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        ex_mem_i = '0;
        prev_we = 1'b0; prev_addr = 5'd0; prev_data = 32'd0;
        @(negedge clk_i);
        check("rst_mid_mem_wb", 64'(mem_wb_o), 64'd0);
        check("rst_mid_stall", 64'(stall_o), 64'd0);
        check("rst_mid_req", 64'(data_req_o), 64'd0);
        @(negedge clk_i);
        check("rst_late_rvalid_mem_wb", 64'(mem_wb_o), 64'd0);

        op = '0;
        repeat (3) issue(op, 32'd0, 0, 1);
        check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
        check("req_queue_empty", 64'(req_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
